// File: rtl/sang_dan_tat_dan.sv
// sang_dan_tat_dan: 8-LED "fill then drain" chaser.
// A 4-bit step index walks a 16-step pattern. The first nine steps light
// the LEDs from bit 0 upward (00..FF). The last seven steps turn them off
// from bit 0 upward (FE..80). A prescaler counts enabled cycles, so one
// step takes STEP_DIV enabled clocks. Disabled cycles freeze everything,
// including the partial prescaler count.
// Optional build macro SDTD_STATUS_EN adds two outputs:
//   phase: registered, 1 while the pattern is in the drain half.
//   wrap:  one-cycle pulse on the edge where the index goes 15 -> 0.
module sang_dan_tat_dan #(
   parameter int unsigned STEP_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [7:0] q
`ifdef SDTD_STATUS_EN
   ,
   output logic       phase,
   output logic       wrap
`endif
);

   localparam logic [15:0] P_LAST = 16'(STEP_DIV - 1);

   logic [3:0]  s_q, s_d;
   logic [15:0] p_q, p_d;
   logic [7:0]  q_q, q_d;

   // Map a step index to its LED pattern. Every index has a defined
   // pattern, so q can never show anything outside the 16-entry sequence.
   function automatic logic [7:0] pattern(input logic [3:0] s);
      logic [8:0] fill;
      begin
         fill = (9'd1 << s) - 9'd1;
         if (s <= 4'd8)
            pattern = fill[7:0];
         else
            pattern = 8'hFF << (s - 4'd8);
      end
   endfunction

   // Advance the prescaler and step index on enabled cycles; hold otherwise.
   always_comb begin
      s_d = s_q;
      p_d = p_q;
      if (enable) begin
         if (p_q == P_LAST) begin
            p_d = 16'd0;
            s_d = s_q + 4'd1;
         end else begin
            p_d = p_q + 16'd1;
         end
      end
      q_d = pattern(s_d);
   end

   // State register; q is registered alongside s so both change together.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s_q <= 4'd0;
         p_q <= 16'd0;
         q_q <= 8'h00;
      end else begin
         s_q <= s_d;
         p_q <= p_d;
         q_q <= q_d;
      end
   end

   assign q = q_q;

`ifdef SDTD_STATUS_EN
   logic phase_q, phase_d;
   logic wrap_q, wrap_d;

   // Phase tracks the next index. Wrap fires only on the step out of index 15.
   always_comb begin
      phase_d = (s_d >= 4'd9);
      wrap_d  = enable && (p_q == P_LAST) && (s_q == 4'd15);
   end

   // Status registers share the main reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         phase_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
      end
   end

   assign phase = phase_q;
   assign wrap  = wrap_q;
`endif

endmodule

// File: tb/tb_sang_dan_tat_dan.sv
// Directed bench for sang_dan_tat_dan. It uses two instances: STEP_DIV=1 and STEP_DIV=4.
// Expected q values come from a hand-written 16-entry pattern table.
module tb_sang_dan_tat_dan;

   logic       clk;
   logic       rst1, en1, rst4, en4;
   logic [7:0] q1, q4;
   int         checks;
   int         errors;
   logic [7:0] tab [16];
   int         s1, s4, p4;
   logic       wrap1_e;
`ifdef SDTD_STATUS_EN
   logic       phase1, wrap1, phase4, wrap4;
`endif

   sang_dan_tat_dan #(.STEP_DIV(1)) dut1 (
      .clk(clk), .reset(rst1), .enable(en1), .q(q1)
`ifdef SDTD_STATUS_EN
      , .phase(phase1), .wrap(wrap1)
`endif
   );

   sang_dan_tat_dan #(.STEP_DIV(4)) dut4 (
      .clk(clk), .reset(rst4), .enable(en4), .q(q4)
`ifdef SDTD_STATUS_EN
      , .phase(phase4), .wrap(wrap4)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %b exp %b", tag, got, exp);
      end
   endtask

   // One clock on dut1 with the given enable/reset. The model is updated, then checked.
   task automatic tick1(input string tag, input logic en, input logic rst);
      en1  = en;
      rst1 = rst;
      @(posedge clk);
      #1;
      wrap1_e = 1'b0;
      if (!rst) s1 = 0;
      else if (en) begin
         wrap1_e = (s1 == 15);
         s1 = (s1 + 1) % 16;
      end
      chk8(tag, q1, tab[s1]);
`ifdef SDTD_STATUS_EN
      chk1({tag, "_phase"}, phase1, (s1 >= 9));
      chk1({tag, "_wrap"}, wrap1, wrap1_e);
`endif
   endtask

   // One clock on dut4 with the given enable. A prescaler model is checked against q4.
   task automatic tick4(input string tag, input logic en);
      en4 = en;
      @(posedge clk);
      #1;
      if (en) begin
         if (p4 == 3) begin
            p4 = 0;
            s4 = (s4 + 1) % 16;
         end else p4++;
      end
      chk8(tag, q4, tab[s4]);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tab = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
              8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
      s1 = 0; s4 = 0; p4 = 0; wrap1_e = 1'b0;
      rst1 = 1'b0; en1 = 1'b1; rst4 = 1'b0; en4 = 1'b1;

      // Reset held with enable high: q stays 00 on both instances.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk8("rst_q1", q1, 8'h00);
         chk8("rst_q4", q4, 8'h00);
      end

      // Full period at STEP_DIV=1. The 16th edge wraps back to 00.
      for (int i = 0; i < 16; i++) tick1("run16", 1'b1, 1'b1);
      chk8("wrap_to_00", q1, 8'h00);

      // Enable toggling every 5 clocks: 5 steps per high window, hold while low.
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 5; i++) tick1("en_hi", 1'b1, 1'b1);
         for (int i = 0; i < 5; i++) tick1("en_lo", 1'b0, 1'b1);
      end
      chk8("after_toggle", q1, 8'hFC);

      // Advance to E0, then assert reset with enable high.
      for (int i = 0; i < 3; i++) tick1("to_E0", 1'b1, 1'b1);
      chk8("at_E0", q1, 8'hE0);
      tick1("rst_mid", 1'b1, 1'b0);
      chk8("rst_mid_00", q1, 8'h00);
      tick1("restart", 1'b1, 1'b1);
      chk8("restart_01", q1, 8'h01);

      // STEP_DIV=4: q changes only on the 4th enabled edge.
      rst4 = 1'b1;
      for (int i = 0; i < 4; i++) tick4("div4_a", 1'b1);
      chk8("div4_first", q4, 8'h01);
      for (int i = 0; i < 2; i++) tick4("div4_b", 1'b1);
      for (int i = 0; i < 3; i++) tick4("div4_hold", 1'b0);
      tick4("div4_c", 1'b1);
      chk8("div4_not_yet", q4, 8'h01);
      tick4("div4_d", 1'b1);
      chk8("div4_done", q4, 8'h03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop if the directed sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
